// File: rtl/si_requant_pipe.sv
`default_nettype none
// ============================================================================
// Module      : si_requant_pipe
// Description : Pipelined per-channel requantizer (0Q32 multiply, shift,
//               rounding, zero-point, saturation) with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module si_requant_pipe #(
    parameter int          N_IN      = 32,
    parameter int          N_OUT     = 8,
    parameter int          N_CH      = 4,
    parameter int          ROUND     = 1,
    parameter logic [31:0] M0_RST    = 32'd1932735283,
    parameter int          SHIFT_RST = 10,
    localparam int         CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [CW-1:0]           cfg_ch,
    input  logic [31:0]             cfg_m0,
    input  logic [4:0]              cfg_shift,
    input  logic [N_OUT-1:0]        cfg_zp,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN-1:0]         in_data,
    input  logic [CW-1:0]           in_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [N_OUT-1:0] out_data,
    output logic [CW-1:0]           out_ch,
    output logic                    out_sat,
    output logic [15:0]             sat_count,
    input  logic                    sat_clr
);

    localparam int PW = N_IN + 33;
    // Headroom for the rounding constant 2^(S-1) with S up to 63.
    localparam int AW = (N_IN + 34 > 65) ? N_IN + 34 : 65;
    localparam int NE = 1 << CW;

    localparam logic [CW:0]          c_nch  = (CW+1)'(N_CH);
    localparam logic [AW-1:0]        c_one  = AW'(1);
    localparam logic signed [AW:0]   c_vmax = $signed({{(AW+2-N_OUT){1'b0}}, {(N_OUT-1){1'b1}}});
    localparam logic signed [AW:0]   c_vmin = $signed({{(AW+2-N_OUT){1'b1}}, {(N_OUT-1){1'b0}}});

    logic [31:0]          r_m0    [NE];
    logic [4:0]           r_shift [NE];
    logic [N_OUT-1:0]     r_zp    [NE];

    logic                 r_s1_valid;
    logic [N_IN-1:0]      r_s1_data;
    logic [CW-1:0]        r_s1_ch;
    logic [31:0]          r_s1_m0;
    logic [4:0]           r_s1_shift;
    logic [N_OUT-1:0]     r_s1_zp;

    logic                 r_s2_valid;
    logic signed [PW-1:0] r_s2_prod;
    logic [CW-1:0]        r_s2_ch;
    logic [4:0]           r_s2_shift;
    logic [N_OUT-1:0]     r_s2_zp;

    logic                 r_s3_valid;
    logic signed [AW-1:0] r_s3_r;
    logic [CW-1:0]        r_s3_ch;
    logic [N_OUT-1:0]     r_s3_zp;

    logic                 w_advance;
    logic                 w_cfg_ok;
    logic signed [PW-1:0] w_prod;
    logic [AW-1:0]        w_ext;
    logic [5:0]           w_sh;
    logic [AW-1:0]        w_half;
    logic [AW-1:0]        w_sum;
    logic signed [AW-1:0] w_r;
    logic signed [AW:0]   w_v;
    logic                 w_hi;
    logic                 w_lo;
    logic [N_OUT-1:0]     w_q;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_cfg_ok  = ({1'b0, cfg_ch} < c_nch);

    assign w_prod = $signed({{33{r_s1_data[N_IN-1]}}, r_s1_data})
                  * $signed({{N_IN{1'b0}}, 1'b0, r_s1_m0});

    assign w_ext  = {{(AW-PW){r_s2_prod[PW-1]}}, r_s2_prod};
    assign w_sh   = 6'd32 + {1'b0, r_s2_shift};
    assign w_half = (ROUND != 0) ? (c_one << (w_sh - 6'd1)) : '0;
    assign w_sum  = w_ext + w_half;
    assign w_r    = $signed(w_sum) >>> w_sh;

    assign w_v  = {r_s3_r[AW-1], r_s3_r} + {{(AW+1-N_OUT){r_s3_zp[N_OUT-1]}}, r_s3_zp};
    assign w_hi = (w_v > c_vmax);
    assign w_lo = (w_v < c_vmin);
    assign w_q  = w_hi ? {1'b0, {(N_OUT-1){1'b1}}} :
                  w_lo ? {1'b1, {(N_OUT-1){1'b0}}} : w_v[N_OUT-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NE; i++) begin
                r_m0[i]    <= M0_RST;
                r_shift[i] <= 5'(SHIFT_RST);
                r_zp[i]    <= '0;
            end
        end else if (cfg_we && w_cfg_ok) begin
            r_m0[cfg_ch]    <= cfg_m0;
            r_shift[cfg_ch] <= cfg_shift;
            r_zp[cfg_ch]    <= cfg_zp;
        end
    end

    // Config is captured at accept time and rides along with the sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_ch    <= '0;
            r_s1_m0    <= '0;
            r_s1_shift <= '0;
            r_s1_zp    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_ch    <= '0;
            r_s2_shift <= '0;
            r_s2_zp    <= '0;
            r_s3_valid <= 1'b0;
            r_s3_r     <= '0;
            r_s3_ch    <= '0;
            r_s3_zp    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            out_sat    <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s1_data  <= in_data;
            r_s1_ch    <= in_ch;
            r_s1_m0    <= r_m0[in_ch];
            r_s1_shift <= r_shift[in_ch];
            r_s1_zp    <= r_zp[in_ch];
            r_s2_valid <= r_s1_valid;
            r_s2_prod  <= w_prod;
            r_s2_ch    <= r_s1_ch;
            r_s2_shift <= r_s1_shift;
            r_s2_zp    <= r_s1_zp;
            r_s3_valid <= r_s2_valid;
            r_s3_r     <= w_r;
            r_s3_ch    <= r_s2_ch;
            r_s3_zp    <= r_s2_zp;
            out_valid  <= r_s3_valid;
            out_data   <= w_q;
            out_ch     <= r_s3_ch;
            out_sat    <= w_hi || w_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || sat_clr) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: doc/si_requant_pipe.md
# si_requant_pipe

Pipelined, multi-channel successor to the combinational SI downscaler. It requantizes wide signed accumulator values (N_IN bits) to signed N_OUT-bit activations using per-channel fixed-point multipliers (0Q32), per-channel right shifts, a selectable rounding mode, a per-channel output zero-point and saturation. It sits between the MAC accumulator array and the activation buffer, with valid/ready handshakes on both sides and a runtime configuration port.

## Interface
- N_IN, 32, signed input width
- N_OUT, 8, signed output width
- N_CH, 4, channel count; channel index width CW = clog2(N_CH), minimum 1
- ROUND, 1, 0 = floor (arithmetic shift), 1 = round-half-up (add 2^(S-1) before shift)
- M0_RST, 1932735283, reset value of every channel's M0 (0Q32, unsigned)
- SHIFT_RST, 10, reset value of every channel's SHIFT (0..31)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- cfg_we  in  1  write strobe for channel config
- cfg_ch  in  CW  channel to write
- cfg_m0  in  32  unsigned multiplier, value = cfg_m0 / 2^32
- cfg_shift  in  5  extra right shift
- cfg_zp  in  N_OUT  signed output zero-point
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts sample this cycle
- in_data  in  N_IN  signed accumulator
- in_ch  in  CW  channel of sample
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts
- out_data  out  N_OUT  signed requantized result
- out_ch  out  CW  channel, passed through
- out_sat  out  1  result was clamped
- sat_count  out  16  saturation event counter
- sat_clr  in  1  clears sat_count

## Operation
- Config file: N_CH entries {m0, shift, zp}; reset loads M0_RST, SHIFT_RST, zp = 0. cfg_ch >= N_CH ignored.
- Stage 1 (accept): when in_valid && in_ready, register in_data, in_ch and the channel's current {m0, shift, zp}; config is sampled here and travels with the sample.
- Stage 2 (multiply): P = in_data (signed) × {1'b0, m0}, width N_IN+33, exact.
- Stage 3 (scale/clamp): S = 32 + shift; R = P >>> S (ROUND=0) or (P + 2^(S-1)) >>> S (ROUND=1), computed at full width, no intermediate overflow; V = R + zp (sign-extended); clamp V to [-2^(N_OUT-1), 2^(N_OUT-1)-1]; out_sat = 1 when clamped.
- sat_count increments by 1 on every output handshake (out_valid && out_ready) with out_sat = 1; saturates at 0xFFFF; sat_clr has priority over increment same cycle.
- Simultaneous cfg_we and accept on the same channel: sample uses the old config; new config applies from the next accepted sample.

## Timing
- Latency: 3 cycles from accepting edge to out_valid (sample accepted at edge k is presented after edge k+3), pipeline fully stalled otherwise.
- Throughput: 1 sample/cycle while out_ready = 1.
- Stall: global advance = !out_valid || out_ready; in_ready = advance (combinational from out_ready). All stages hold when advance = 0; no sample dropped or duplicated; out_data/out_ch/out_sat stable while out_valid && !out_ready.
- Bubbles propagate as invalid stages; advance=1 with empty stages fills them.
- Reset (rst_n = 0 at an edge): all stage valids 0, out_valid 0, out_data 0, out_ch 0, out_sat 0, sat_count 0, config to reset values; in-flight samples discarded; in_ready = 1 in the first cycle after reset release.
- cfg_we takes effect at the edge it is sampled; visible to a sample accepted on the following edge.

## Test plan
- Reset defaults, ROUND=1, N_CH=4, ch 0, out_ready=1: in 316109 -> 127 sat; -316109 -> -128 sat; 200000 -> 88; -71672 -> -31; -500000 -> -128 sat; each 3 cycles after accept, back-to-back, sat_count ends at 3.
- ROUND=0 instance, same stream: 200000 -> 87, -71672 -> -32, saturating cases unchanged.
- Per-channel config: ch 2 set m0=2^31, shift=0, zp=-5; in 100 on ch2 -> 45, out_ch=2; in 300 on ch2 -> 127 sat; ch 0 still using reset config in the same stream.
- Backpressure: stream 8 samples, out_ready low for 4 cycles mid-stream -> in_ready low, outputs held stable, all 8 results delivered in order, no duplicates.
- Config race: cfg_we to ch1 (zp=10) same cycle as ch1 sample accept -> that sample uses zp=0, next ch1 sample uses zp=10.
- Reset mid-stream with 3 samples in flight -> out_valid 0 next cycle, sat_count 0, no stale outputs after release; sat_clr with concurrent saturating handshake -> sat_count 0.
